// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between IF-stage fetches and loader writes.
// Reads take MEM_LAT cycles; fetch_stall freezes the PC until the fetched word is presented.
module imem_port_arbiter #(
   parameter int unsigned MEM_LAT  = 2,
   parameter int unsigned LD_BURST = 4,
   parameter int unsigned AW       = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [31:0]   if_rdata_o,
   output logic          if_rvalid_o,
   output logic          fetch_stall_o,
   input  logic          ld_req_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [31:0]   ld_wdata_i,
   output logic          ld_gnt_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-3:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i
);

   localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned BW = $clog2(LD_BURST + 1);
   localparam logic [LW-1:0] LAT_INIT  = LW'(MEM_LAT - 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(LD_BURST);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [AW-3:0] addr_q, addr_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          mem_en_s;
   logic          mem_we_s;
   logic [AW-3:0] mem_addr_s;
   logic [31:0]   mem_wdata_s;
   logic          ld_gnt_s;
   logic          rvalid_s;
   logic          addr_lsb_unused_s;

   // Byte-offset bits carry no meaning for a word-addressed memory.
   assign addr_lsb_unused_s = ^{if_addr_i[1:0], ld_addr_i[1:0]};

   // Arbitration and next-state decode; IDLE decisions strobe the memory in the same cycle.
   always_comb begin
      state_d     = state_q;
      burst_d     = burst_q;
      lat_d       = lat_q;
      addr_d      = addr_q;
      rdata_d     = rdata_q;
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = 32'h0000_0000;
      ld_gnt_s    = 1'b0;
      rvalid_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld_req_i && !(if_req_i && (burst_q == BURST_MAX))) begin
               state_d     = ST_WRITE;
               mem_en_s    = 1'b1;
               mem_we_s    = 1'b1;
               mem_addr_s  = ld_addr_i[AW-1:2];
               mem_wdata_s = ld_wdata_i;
               ld_gnt_s    = 1'b1;
               // The starvation counter only runs while a fetch is actually being held off.
               if (if_req_i && (burst_q != BURST_MAX)) begin
                  burst_d = burst_q + 1'b1;
               end else begin
                  burst_d = burst_q;
               end
            end else if (if_req_i) begin
               state_d    = ST_READ;
               mem_en_s   = 1'b1;
               mem_addr_s = if_addr_i[AW-1:2];
               lat_d      = LAT_INIT;
               burst_d    = '0;
               addr_d     = if_addr_i[AW-1:2];
            end else begin
               burst_d = '0;
            end
         end
         ST_READ: begin
            mem_addr_s = addr_q;
            if (lat_q == '0) begin
               rvalid_s = 1'b1;
               rdata_d  = mem_rdata_i;
               state_d  = ST_IDLE;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_en_o      = rst_i & mem_en_s;
   assign mem_we_o      = rst_i & mem_we_s;
   assign mem_addr_o    = rst_i ? mem_addr_s : '0;
   assign mem_wdata_o   = rst_i ? mem_wdata_s : 32'h0000_0000;
   assign ld_gnt_o      = rst_i & ld_gnt_s;
   assign if_rvalid_o   = rst_i & rvalid_s;
   assign fetch_stall_o = ~(rst_i & rvalid_s);
   assign if_rdata_o    = (rst_i && rvalid_s) ? mem_rdata_i : rdata_q;

   // State, counters, latched address and held fetch data; reset abandons any read in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         burst_q <= '0;
         lat_q   <= '0;
         addr_q  <= '0;
         rdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
